// File: rtl/branch_predictor_arbiter.sv
// ---------------------------------------------------------------------------
// branch_predictor_arbiter
//
// Shares the single address port of a saturating branch predictor between a
// fetch-side lookup requester and an execute-side update requester. Lookups
// have priority; resolved branches are queued in an in-order update FIFO and
// drained in idle cycles, by a starvation override, or by a forced flush
// once the FIFO fills.
//
// Optional feature macro: PRED_ARB_BYPASS_EN
//   When defined, an update offered while the arbiter is NORMAL, the FIFO is
//   empty and no lookup is requested goes straight to the predictor in the
//   same cycle instead of being queued.
//
// Parameters:
//   ADDRESS_WIDTH  predictor index width (matches predictor address_width)
//   FIFO_DEPTH     update FIFO entries, power of two, >= 2
//   STARVE_LIMIT   stalled cycles with pending updates before a forced update
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lookup_req/address       fetch prediction request
//   lookup_gnt               combinational, lookup issued this cycle
//   resp_valid               registered, cycle after a granted lookup
//   resp_prediction          predictor output passed through
//   update_valid/address/taken, update_ready   execute update handshake
//   pred_cs, pred_enable, pred_address, pred_branch_result  predictor drive
//   pred_prediction          predictor registered prediction output
// ---------------------------------------------------------------------------
module branch_predictor_arbiter #(
    parameter int ADDRESS_WIDTH = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_req,
    input  logic [ADDRESS_WIDTH-1:0] lookup_address,
    output logic                     lookup_gnt,
    output logic                     resp_valid,
    output logic                     resp_prediction,
    input  logic                     update_valid,
    input  logic [ADDRESS_WIDTH-1:0] update_address,
    input  logic                     update_taken,
    output logic                     update_ready,
    output logic                     pred_cs,
    output logic                     pred_enable,
    output logic [ADDRESS_WIDTH-1:0] pred_address,
    output logic                     pred_branch_result,
    input  logic                     pred_prediction
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_LOOKUP,
        CMD_UPDATE
    } cmd_t;

    state_t state, state_n;
    cmd_t   cmd;

    logic [ADDRESS_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic                     fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         count, count_n;
    logic [STV_W-1:0]         starve_cnt, starve_n;

    logic                     fifo_empty, fifo_full, starve_hit;
    logic                     push, pop, bypass;
    logic [ADDRESS_WIDTH-1:0] upd_addr;
    logic                     upd_taken;

    // Last driven address/result, held on the predictor port during IDLE.
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     result_q;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign starve_hit = (starve_cnt == STV_W'(STARVE_LIMIT));

    // Arbitration and next-state logic
    always_comb begin
        state_n      = state;
        cmd          = CMD_IDLE;
        pop          = 1'b0;
        push         = 1'b0;
        bypass       = 1'b0;
        lookup_gnt   = 1'b0;
        update_ready = 1'b0;
        upd_addr     = fifo_addr[rd_ptr];
        upd_taken    = fifo_taken[rd_ptr];
        count_n      = count;

        if (!rst) begin
            update_ready = !fifo_full;

            case (state)
                ST_NORMAL: begin
                    // Starvation override is checked before lookup priority.
                    if (starve_hit && !fifo_empty) begin
                        pop = 1'b1;
                        cmd = CMD_UPDATE;
                    end else if (lookup_req) begin
                        lookup_gnt = 1'b1;
                        cmd        = CMD_LOOKUP;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                        cmd = CMD_UPDATE;
                    end
`ifdef PRED_ARB_BYPASS_EN
                    else if (update_valid) begin
                        bypass    = 1'b1;
                        cmd       = CMD_UPDATE;
                        upd_addr  = update_address;
                        upd_taken = update_taken;
                    end
`endif
                end
                ST_FLUSH: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        cmd = CMD_UPDATE;
                    end
                end
                default: state_n = ST_NORMAL;
            endcase

            push = update_valid && update_ready && !bypass;

            case ({push, pop})
                2'b10:   count_n = count + CNT_W'(1);
                2'b01:   count_n = count - CNT_W'(1);
                default: count_n = count;
            endcase

            if (state == ST_NORMAL && count_n == CNT_W'(FIFO_DEPTH)) begin
                state_n = ST_FLUSH;
            end else if (state == ST_FLUSH && count_n == '0) begin
                state_n = ST_NORMAL;
            end
        end
    end

    // Predictor port drive
    always_comb begin
        pred_enable        = (cmd != CMD_IDLE);
        pred_cs            = (cmd == CMD_UPDATE);
        pred_address       = addr_q;
        pred_branch_result = result_q;
        if (cmd == CMD_LOOKUP) begin
            pred_address = lookup_address;
        end else if (cmd == CMD_UPDATE) begin
            pred_address       = upd_addr;
            pred_branch_result = upd_taken;
        end
    end

    always_comb begin
        starve_n = starve_cnt;
        if (fifo_empty || pop) begin
            starve_n = '0;
        end else if (!starve_hit) begin
            starve_n = starve_cnt + STV_W'(1);
        end
    end

    assign resp_prediction = pred_prediction;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORMAL;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            addr_q     <= '0;
            result_q   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            starve_cnt <= starve_n;
            resp_valid <= (cmd == CMD_LOOKUP);
            addr_q     <= pred_address;
            result_q   <= pred_branch_result;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= update_address;
            fifo_taken[wr_ptr] <= update_taken;
        end
    end

endmodule

// File: tb/tb_branch_predictor_arbiter.sv
module tb_branch_predictor_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       lookup_req;
    logic [0:0] lookup_address;
    logic       lookup_gnt;
    logic       resp_valid;
    logic       resp_prediction;
    logic       update_valid;
    logic [0:0] update_address;
    logic       update_taken;
    logic       update_ready;
    logic       pred_cs;
    logic       pred_enable;
    logic [0:0] pred_address;
    logic       pred_branch_result;
    logic       pred_prediction;

    int tests = 0;
    int fails = 0;

`ifdef PRED_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    branch_predictor_arbiter #(
        .ADDRESS_WIDTH(1),
        .FIFO_DEPTH(4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lookup_req         (lookup_req),
        .lookup_address     (lookup_address),
        .lookup_gnt         (lookup_gnt),
        .resp_valid         (resp_valid),
        .resp_prediction    (resp_prediction),
        .update_valid       (update_valid),
        .update_address     (update_address),
        .update_taken       (update_taken),
        .update_ready       (update_ready),
        .pred_cs            (pred_cs),
        .pred_enable        (pred_enable),
        .pred_address       (pred_address),
        .pred_branch_result (pred_branch_result),
        .pred_prediction    (pred_prediction)
    );

    // Saturating 2-bit counter predictor driven by the arbiter.
    logic [1:0] ctr [2];
    always @(posedge clk) begin
        if (rst) begin
            ctr[0]          <= 2'd0;
            ctr[1]          <= 2'd0;
            pred_prediction <= 1'b0;
        end else if (pred_enable) begin
            if (pred_cs) begin
                if (pred_branch_result && ctr[pred_address] != 2'd3)
                    ctr[pred_address] <= ctr[pred_address] + 2'd1;
                else if (!pred_branch_result && ctr[pred_address] != 2'd0)
                    ctr[pred_address] <= ctr[pred_address] - 2'd1;
            end else begin
                pred_prediction <= ctr[pred_address][1];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_req     = 1'b0;
        lookup_address = 1'b0;
        update_valid   = 1'b0;
        update_address = 1'b0;
        update_taken   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lookup_req   = 1'b1;
        update_valid = 1'b1;
        @(negedge clk);
        tests++; if (lookup_gnt !== 1'b0) begin fails++; $display("FAIL rst_gnt got %b want 0", lookup_gnt); end
        tests++; if (update_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", update_ready); end
        tests++; if (pred_cs !== 1'b0 || pred_enable !== 1'b0) begin fails++; $display("FAIL rst_cmd got cs=%b en=%b want 0 0", pred_cs, pred_enable); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL post_rst_resp got %b want 0", resp_valid); end
        tests++; if (pred_address !== 1'b0 || pred_branch_result !== 1'b0) begin fails++; $display("FAIL post_rst_addr got a=%b r=%b want 0 0", pred_address, pred_branch_result); end
        tests++; if (update_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b want 1", update_ready); end
        next_cycle();
    endtask

    task automatic test_lookup();
        for (int i = 0; i < 5; i++) begin
            lookup_req     = (i < 3);
            lookup_address = 1'b1;
            @(negedge clk);
            if (i < 3) begin
                tests++;
                if (lookup_gnt !== 1'b1 || pred_enable !== 1'b1 || pred_cs !== 1'b0 || pred_address !== 1'b1) begin
                    fails++;
                    $display("FAIL lookup_cmd[%0d] got gnt=%b en=%b cs=%b a=%b want 1 1 0 1", i, lookup_gnt, pred_enable, pred_cs, pred_address);
                end
            end
            tests++;
            if (resp_valid !== (i >= 1 && i <= 3)) begin
                fails++; $display("FAIL lookup_resp_valid[%0d] got %b want %b", i, resp_valid, (i >= 1 && i <= 3));
            end
            if (i >= 1 && i <= 3) begin
                tests++;
                if (resp_prediction !== 1'b0) begin fails++; $display("FAIL lookup_pred[%0d] got %b want 0", i, resp_prediction); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_update_path();
        for (int k = 0; k < 3; k++) begin
            update_valid   = 1'b1;
            update_address = 1'b0;
            update_taken   = 1'b1;
            @(negedge clk);
            tests++; if (update_ready !== 1'b1) begin fails++; $display("FAIL upd_ready[%0d] got %b want 1", k, update_ready); end
            tests++; if (pred_cs !== BYP) begin fails++; $display("FAIL upd_accept_cs[%0d] got %b want %b", k, pred_cs, BYP); end
            next_cycle();
            update_valid = 1'b0;
            @(negedge clk);
            tests++; if (pred_cs !== !BYP) begin fails++; $display("FAIL upd_drain_cs[%0d] got %b want %b", k, pred_cs, !BYP); end
            if (!BYP) begin
                tests++;
                if (pred_enable !== 1'b1 || pred_address !== 1'b0 || pred_branch_result !== 1'b1) begin
                    fails++; $display("FAIL upd_drain_port[%0d] got en=%b a=%b r=%b want 1 0 1", k, pred_enable, pred_address, pred_branch_result);
                end
            end
            tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL upd_resp_valid[%0d] got %b want 0", k, resp_valid); end
            next_cycle();
        end
        @(negedge clk);
        tests++;
        if (pred_enable !== 1'b0 || pred_address !== 1'b0 || pred_branch_result !== 1'b1) begin
            fails++; $display("FAIL idle_hold got en=%b a=%b r=%b want 0 0 1", pred_enable, pred_address, pred_branch_result);
        end
        next_cycle();
        lookup_req     = 1'b1;
        lookup_address = 1'b0;
        @(negedge clk);
        tests++; if (lookup_gnt !== 1'b1) begin fails++; $display("FAIL upd_lookup_gnt got %b want 1", lookup_gnt); end
        next_cycle();
        lookup_req = 1'b0;
        @(negedge clk);
        tests++;
        if (resp_valid !== 1'b1 || resp_prediction !== 1'b1) begin
            fails++; $display("FAIL upd_lookup_resp got v=%b p=%b want 1 1", resp_valid, resp_prediction);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_starvation();
        lookup_req     = 1'b1;
        lookup_address = 1'b0;
        update_valid   = 1'b1;
        update_address = 1'b1;
        update_taken   = 1'b0;
        @(negedge clk);
        tests++;
        if (lookup_gnt !== 1'b1 || update_ready !== 1'b1 || pred_cs !== 1'b0) begin
            fails++; $display("FAIL starve_push got gnt=%b rdy=%b cs=%b want 1 1 0", lookup_gnt, update_ready, pred_cs);
        end
        next_cycle();
        update_valid = 1'b0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            tests++;
            if (lookup_gnt !== (i != 9) || pred_cs !== (i == 9)) begin
                fails++; $display("FAIL starve_cycle[%0d] got gnt=%b cs=%b want %b %b", i, lookup_gnt, pred_cs, (i != 9), (i == 9));
            end
            if (i == 9) begin
                tests++;
                if (pred_address !== 1'b1 || pred_branch_result !== 1'b0) begin
                    fails++; $display("FAIL starve_port got a=%b r=%b want 1 0", pred_address, pred_branch_result);
                end
            end
            tests++;
            if (resp_valid !== (i != 10)) begin
                fails++; $display("FAIL starve_resp[%0d] got %b want %b", i, resp_valid, (i != 10));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_flush();
        logic [0:0] fa [4];
        logic       ft [4];
        fa[0] = 1'b1; fa[1] = 1'b0; fa[2] = 1'b1; fa[3] = 1'b0;
        ft[0] = 1'b1; ft[1] = 1'b0; ft[2] = 1'b0; ft[3] = 1'b1;
        lookup_req     = 1'b1;
        lookup_address = 1'b0;
        for (int i = 0; i < 10; i++) begin
            update_valid = (i < 4);
            if (i < 4) begin
                update_address = fa[i];
                update_taken   = ft[i];
            end
            @(negedge clk);
            tests++;
            if (lookup_gnt !== (i < 4 || i >= 8) || pred_cs !== (i >= 4 && i < 8)) begin
                fails++; $display("FAIL flush_cmd[%0d] got gnt=%b cs=%b want %b %b", i, lookup_gnt, pred_cs, (i < 4 || i >= 8), (i >= 4 && i < 8));
            end
            tests++;
            if (update_ready !== (i != 4)) begin
                fails++; $display("FAIL flush_ready[%0d] got %b want %b", i, update_ready, (i != 4));
            end
            if (i >= 4 && i < 8) begin
                tests++;
                if (pred_address !== fa[i-4] || pred_branch_result !== ft[i-4]) begin
                    fails++; $display("FAIL flush_order[%0d] got a=%b r=%b want %b %b", i, pred_address, pred_branch_result, fa[i-4], ft[i-4]);
                end
            end
            tests++;
            if (resp_valid !== ((i >= 1 && i <= 4) || i >= 9)) begin
                fails++; $display("FAIL flush_resp[%0d] got %b want %b", i, resp_valid, ((i >= 1 && i <= 4) || i >= 9));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_drop();
        for (int i = 0; i < 3; i++) begin
            lookup_req     = 1'b1;
            lookup_address = 1'b1;
            update_valid   = 1'b1;
            update_address = 1'b0;
            update_taken   = 1'b1;
            @(negedge clk);
            tests++;
            if (update_ready !== 1'b1 || pred_cs !== 1'b0) begin
                fails++; $display("FAIL drop_push[%0d] got rdy=%b cs=%b want 1 0", i, update_ready, pred_cs);
            end
            next_cycle();
        end
        idle_inputs();
        rst        = 1'b1;
        lookup_req = 1'b1;
        @(negedge clk);
        tests++;
        if (pred_cs !== 1'b0 || lookup_gnt !== 1'b0 || update_ready !== 1'b0) begin
            fails++; $display("FAIL drop_rst got cs=%b gnt=%b rdy=%b want 0 0 0", pred_cs, lookup_gnt, update_ready);
        end
        next_cycle();
        rst        = 1'b0;
        lookup_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (pred_cs !== 1'b0 || pred_enable !== 1'b0 || update_ready !== 1'b1 || resp_valid !== 1'b0 ||
                pred_address !== 1'b0 || pred_branch_result !== 1'b0) begin
                fails++;
                $display("FAIL drop_after[%0d] got cs=%b en=%b rdy=%b rv=%b a=%b r=%b want 0 0 1 0 0 0",
                         i, pred_cs, pred_enable, update_ready, resp_valid, pred_address, pred_branch_result);
            end
            next_cycle();
        end
    endtask

`ifdef PRED_ARB_BYPASS_EN
    task automatic test_bypass();
        update_valid   = 1'b1;
        update_address = 1'b1;
        update_taken   = 1'b0;
        @(negedge clk);
        tests++;
        if (pred_cs !== 1'b1 || pred_enable !== 1'b1 || pred_address !== 1'b1 || pred_branch_result !== 1'b0 || update_ready !== 1'b1) begin
            fails++; $display("FAIL bypass_same got cs=%b en=%b a=%b r=%b rdy=%b want 1 1 1 0 1",
                              pred_cs, pred_enable, pred_address, pred_branch_result, update_ready);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        tests++;
        if (pred_cs !== 1'b0 || pred_enable !== 1'b0) begin
            fails++; $display("FAIL bypass_not_queued got cs=%b en=%b want 0 0", pred_cs, pred_enable);
        end
        next_cycle();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lookup();
        test_update_path();
        test_starvation();
        test_flush();
        test_reset_drop();
`ifdef PRED_ARB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor_arbiter.md
# branch_predictor_arbiter

Shares the single address port of the saturating branch predictor between a fetch-side lookup requester and an execute-side update requester. Lookups have priority. Resolved branch outcomes are buffered in a small update FIFO and drained into the predictor in idle cycles, by starvation override, or by forced flush when the FIFO fills. It sits between the fetch/execute stages and the predictor instance and drives the predictor's cs/enable/address/result inputs.

## Interface
- ADDRESS_WIDTH, 1: predictor index width; must match the predictor's address_width.
- FIFO_DEPTH, 4: update FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive stalled cycles with a non-empty FIFO before a forced update; ≥1.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- lookup_req  in  1  fetch requests a prediction.
- lookup_address  in  ADDRESS_WIDTH  index to predict.
- lookup_gnt  out  1  combinational; lookup issued this cycle.
- resp_valid  out  1  registered; asserted the cycle after a granted lookup.
- resp_prediction  out  1  equals pred_prediction; meaningful only when resp_valid=1.
- update_valid  in  1  execute offers a resolved branch.
- update_address  in  ADDRESS_WIDTH  resolved branch index.
- update_taken  in  1  resolved outcome.
- update_ready  out  1  combinational; update accepted when update_valid && update_ready.
- pred_cs, pred_enable  out  1 each  predictor controls.
- pred_address  out  ADDRESS_WIDTH  predictor index.
- pred_branch_result  out  1  predictor update outcome.
- pred_prediction  in  1  predictor's registered prediction output.

## Operation
- Per-cycle predictor command, one of:
  - LOOKUP: enable=1, cs=0, address=lookup_address.
  - UPDATE: enable=1, cs=1, address/result from the FIFO head (or the bypass).
  - IDLE: enable=0, cs=0; address/result hold their previous values.
- Two-state FSM:
  - NORMAL:
    - lookup_req wins: lookup_gnt=1, command LOOKUP.
    - With no lookup_req and the FIFO non-empty: pop the head and issue UPDATE.
    - Otherwise IDLE.
    - Starvation override: when starve_cnt==STARVE_LIMIT and the FIFO is non-empty, pop and issue UPDATE, and force lookup_gnt=0 for that cycle.
  - FLUSH: entered the cycle after count reaches FIFO_DEPTH. lookup_gnt=0; UPDATE every cycle until empty; return to NORMAL the cycle after the last pop.
- starve_cnt:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on any pop and whenever the FIFO is empty.
- update_ready = (count != FIFO_DEPTH), in both states.
- FIFO ordering and counting:
  - FIFO is strictly in order.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.
- Updates to the same address are applied in acceptance order. No coalescing.
- resp_valid is set only when the previous cycle was LOOKUP. After UPDATE or IDLE cycles the predictor output is stale or clobbered, so resp_valid=0.
- Reset: state NORMAL, FIFO emptied (queued updates dropped), starve_cnt=0, resp_valid=0, pred_cs=0, pred_enable=0, pred_address=0, pred_branch_result=0. In the reset cycle lookup_gnt=0 and update_ready=0.

## Timing
- Lookup latency: grant in cycle N, resp_valid/resp_prediction in cycle N+1. Back-to-back lookups give one response per cycle.
- Update latency without bypass: accepted in cycle N, earliest UPDATE in cycle N+1. The counter is visible to a lookup granted in N+2.
- Entering FLUSH: FIFO full at the end of cycle N, so lookup_gnt=0 from cycle N+1 for FIFO_DEPTH cycles, or longer if pushes continue.
- Worst-case lookup stall in NORMAL is 1 cycle per STARVE_LIMIT cycles.

## Configuration
- PRED_ARB_BYPASS_EN defined:
  - Applies in NORMAL with the FIFO empty, lookup_req=0 and update_valid=1.
  - The update is issued directly as UPDATE in the same cycle and is not enqueued.
- Not defined: every update passes through the FIFO; minimum 1-cycle queue latency.

## Test plan
- Reset then lookup_req=1, lookup_address=1 for 3 cycles → lookup_gnt=1 each cycle; resp_valid=1 on cycles 2–4 with resp_prediction=0.
- Bypass off: push taken to address 0 three times with no lookups, then lookup address 0 → three UPDATEs (one cycle each, starting 1 cycle after each push); response prediction=1.
- Continuous lookup_req with 1 pending update, STARVE_LIMIT=8 → exactly one cycle of lookup_gnt=0 with pred_cs=1 after 8 stalled cycles.
- Continuous lookup_req while pushing 4 updates (FIFO_DEPTH=4) → update_ready=0 at count 4; FLUSH blocks lookups for 4 cycles; lookup_gnt returns the following cycle.
- Assert rst with 3 queued updates → no further pred_cs; after reset update_ready=1, count=0, all outputs 0.
- With PRED_ARB_BYPASS_EN: empty FIFO, single update → pred_cs=1 in the same cycle as acceptance; FIFO count stays 0.
